vend_dispenser: RTL
===================

# vend_dispenser

Dispense-side controller for the vending datapath. It accepts a vend request (soda strobe plus a 3-bit change amount in nickels) from the coin-acceptance FSM and drives the physical ejector solenoids: one soda, then change paid greedily in dimes and nickels. Each ejection is a timed pulse followed by a mechanism acknowledge. It keeps soda, dime and nickel inventory counters and reports sold-out, short-change and jam conditions.

## Interface

Parameters:
- `CNT_W`, 4: inventory counter width.
- `SODA_INIT`, 8: soda count loaded on reset and on refill.
- `DIME_INIT`, 8: dime count loaded on reset and on refill.
- `NICKEL_INIT`, 8: nickel count loaded on reset and on refill.
- `PULSE_CYC`, 4: ejector pulse width in cycles (≥1).
- `ACK_TIMEOUT`, 64: maximum cycles to wait for `mech_done` after a pulse.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `soda`, in, 1: vend request strobe. Sampled only in IDLE.
- `change`, in, 3: change owed in nickels, sampled with `soda`.
- `mech_done`, in, 1: mechanism finished the current ejection.
- `refill`, in, 1: reload all inventories to their INIT values. Honoured only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `eject_soda`, out, 1: soda solenoid pulse.
- `eject_dime`, out, 1: dime solenoid pulse.
- `eject_nickel`, out, 1: nickel solenoid pulse.
- `sold_out`, out, 1: equals `soda_cnt == 0`.
- `short_change`, out, 1: the last transaction could not pay its full change.
- `fault`, out, 1: ejector jam, sticky until reset.
- `soda_cnt`, `dime_cnt`, `nickel_cnt`, out, CNT_W each: live inventory.

## Operation

- States: IDLE, SODA_PULSE, SODA_ACK, SELECT, COIN_PULSE, COIN_ACK, FAULT.
- **IDLE, `soda`=1:**
  - Load `remaining` (4-bit) = `change`, or `change`+PRICE_NICKELS (4) if `soda_cnt`==0 (full refund).
  - Clear `short_change`.
  - Go to SODA_PULSE if `soda_cnt`>0, else go to SELECT.
  - `refill` is ignored on the same cycle; `soda` has priority.
- **IDLE, `refill`=1 with `soda`=0:** all counts load their INIT values.
- **SODA_PULSE:** `eject_soda`=1 for exactly PULSE_CYC cycles. `soda_cnt` decrements on entry. Then go to SODA_ACK.
- **SODA_ACK / COIN_ACK:**
  - Wait for `mech_done`=1, then go to SELECT.
  - `mech_done` during a PULSE state is ignored.
  - If `mech_done` is not seen within ACK_TIMEOUT cycles, go to FAULT.
- **SELECT** (one cycle), first matching rule wins:
  - `remaining`==0 → IDLE.
  - `remaining`≥2 and `dime_cnt`>0 → dime: `remaining`-=2, `dime_cnt`-=1, go to COIN_PULSE.
  - `nickel_cnt`>0 → nickel: `remaining`-=1, `nickel_cnt`-=1, go to COIN_PULSE.
  - Otherwise → set `short_change`=1, go to IDLE.
- **COIN_PULSE:** the selected `eject_dime` or `eject_nickel` is high for PULSE_CYC cycles, then go to COIN_ACK.
- **FAULT:**
  - `fault`=1 and all ejects are 0.
  - `soda` and `refill` are ignored.
  - Only `reset` exits.
- **Change codes 5–7** are accepted arithmetically; `remaining` never overflows (max 11).
- **Counts never underflow:** every decrement is guarded by a >0 check.

## Timing

- **Reset values:**
  - State IDLE; `busy`, all ejects, `short_change` and `fault` = 0.
  - Counts = INIT values; `sold_out` = (SODA_INIT==0).
- **Outputs** are Moore, decoded from registered state.
- **Request at edge N** (IDLE, `soda`=1): `busy`=1 and `eject_soda`=1 from cycle N+1 through N+PULSE_CYC.
- **Acknowledge at edge M** (`mech_done` sampled high in an ACK state): SELECT in cycle M+1, next pulse starts in cycle M+2.
- **Timeout:** the ACK counter starts at 0 on ACK entry. FAULT is entered on the edge where the count reaches ACK_TIMEOUT with no `mech_done`.
- **Return to IDLE:** `busy` falls the cycle after SELECT decides IDLE. A new request is accepted on that same IDLE cycle.
- **Reset mid-operation:** ejects drop at the next edge; counts reload INIT (an in-flight transaction is lost).

## Structure

- **Package `vend_pkg`:**
  - State enum `disp_state_t`.
  - `PRICE_NICKELS` = 4.
  - Coin values `NICKEL_UNITS` = 1, `DIME_UNITS` = 2.
- **Sub-module `eject_timer`:**
  - Inputs: `start`, `ack`.
  - Counts PULSE_CYC for the pulse phase, then ACK_TIMEOUT for the ack phase.
  - Outputs: `pulse_on`, `pulse_done`, `timeout`.
  - Instantiated once and shared by soda and coin ejection.

## Test plan

- **Normal vend, 15c change:** defaults, `soda`=1, `change`=3 with `mech_done` returned 2 cycles after each pulse → `eject_soda`, then `eject_dime`, then `eject_nickel`, each 4 cycles wide. Final counts 7/7/7, `short_change`=0, `busy` low at end.
- **No dimes:** DIME_INIT=0, `change`=4 → soda plus four nickel pulses; `nickel_cnt`=4.
- **Sold out:** SODA_INIT=0 → `sold_out`=1 out of reset. Request with `change`=0 → no `eject_soda`, two dime pulses (20c refund).
- **Short change:** NICKEL_INIT=0, `change`=1 → soda only, `short_change`=1. The next request clears it.
- **Jam:** `mech_done` held 0 after the soda pulse → `fault`=1 exactly ACK_TIMEOUT cycles after SODA_ACK entry. Further requests are ignored; `reset` clears to the reset values.
- **Boundaries:**
  - `refill` while `busy` → counts unchanged.
  - `refill` in IDLE → counts return to INIT.
  - `soda` while `busy` → ignored.
  - `reset` during COIN_PULSE → eject low next cycle, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared state encoding and coin/price constants for the dispense controller.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SODA_PULSE,
        SODA_ACK,
        SELECT,
        COIN_PULSE,
        COIN_ACK,
        FAULT
    } disp_state_t;

    localparam int PRICE_NICKELS = 4;
    localparam int NICKEL_UNITS  = 1;
    localparam int DIME_UNITS    = 2;

endpackage

// File: rtl/eject_timer.sv
// Shared ejector timer: PULSE_CYC-cycle pulse phase, then an ack window that
// flags a timeout after ACK_TIMEOUT cycles without an acknowledge.
module eject_timer #(
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic pulse_on,
    output logic pulse_done,
    output logic timeout
);

    localparam int MAXC = (PULSE_CYC > ACK_TIMEOUT) ? PULSE_CYC : ACK_TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {T_IDLE, T_PULSE, T_ACK} phase_t;

    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pulse_on   = (phase_q == T_PULSE);
    assign pulse_done = pulse_on && (cnt_q == CW'(PULSE_CYC - 1));
    // ack on the final window cycle still wins over the timeout
    assign timeout    = (phase_q == T_ACK) && !ack && (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        if (start) begin
            phase_d = T_PULSE;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                T_PULSE: if (pulse_done) begin
                    phase_d = T_ACK;
                    cnt_d   = '0;
                end
                T_ACK: if (ack || timeout) begin
                    phase_d = T_IDLE;
                    cnt_d   = '0;
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= T_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_dispenser.sv
// Dispense-side controller: one soda, then greedy dime/nickel change, each
// ejection a timed pulse followed by a mechanism acknowledge.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SODA_INIT   = 8,
    parameter int DIME_INIT   = 8,
    parameter int NICKEL_INIT = 8,
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soda,
    input  logic [2:0]       change,
    input  logic             mech_done,
    input  logic             refill,
    output logic             busy,
    output logic             eject_soda,
    output logic             eject_dime,
    output logic             eject_nickel,
    output logic             sold_out,
    output logic             short_change,
    output logic             fault,
    output logic [CNT_W-1:0] soda_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic [CNT_W-1:0] nickel_cnt
);

    disp_state_t      state_q, state_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             coin_dime_q, coin_dime_d;
    logic [CNT_W-1:0] soda_cnt_q, soda_cnt_d;
    logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;
    logic [CNT_W-1:0] nickel_cnt_q, nickel_cnt_d;
    logic             short_change_q, short_change_d;
    logic             busy_q, busy_d;
    logic             eject_soda_q, eject_soda_d;
    logic             eject_dime_q, eject_dime_d;
    logic             eject_nickel_q, eject_nickel_d;
    logic             fault_q, fault_d;

    logic             tmr_start, pulse_on, pulse_done, timeout;

    eject_timer #(
        .PULSE_CYC  (PULSE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (tmr_start),
        .ack       (mech_done),
        .pulse_on  (pulse_on),
        .pulse_done(pulse_done),
        .timeout   (timeout)
    );

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        coin_dime_d    = coin_dime_q;
        soda_cnt_d     = soda_cnt_q;
        dime_cnt_d     = dime_cnt_q;
        nickel_cnt_d   = nickel_cnt_q;
        short_change_d = short_change_q;
        tmr_start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (soda) begin
                    short_change_d = 1'b0;
                    if (soda_cnt_q != '0) begin
                        remaining_d = {1'b0, change};
                        soda_cnt_d  = soda_cnt_q - CNT_W'(1);
                        tmr_start   = 1'b1;
                        state_d     = SODA_PULSE;
                    end else begin
                        // sold out: refund the price along with the change
                        remaining_d = {1'b0, change} + 4'(PRICE_NICKELS);
                        state_d     = SELECT;
                    end
                end else if (refill) begin
                    soda_cnt_d   = CNT_W'(SODA_INIT);
                    dime_cnt_d   = CNT_W'(DIME_INIT);
                    nickel_cnt_d = CNT_W'(NICKEL_INIT);
                end
            end
            SODA_PULSE: if (pulse_done) state_d = SODA_ACK;
            COIN_PULSE: if (pulse_done) state_d = COIN_ACK;
            SODA_ACK, COIN_ACK: begin
                if (mech_done && !pulse_on) state_d = SELECT;
                else if (timeout)           state_d = FAULT;
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    state_d = IDLE;
                end else if (remaining_q >= 4'(DIME_UNITS) && dime_cnt_q != '0) begin
                    remaining_d = remaining_q - 4'(DIME_UNITS);
                    dime_cnt_d  = dime_cnt_q - CNT_W'(1);
                    coin_dime_d = 1'b1;
                    tmr_start   = 1'b1;
                    state_d     = COIN_PULSE;
                end else if (nickel_cnt_q != '0) begin
                    remaining_d  = remaining_q - 4'(NICKEL_UNITS);
                    nickel_cnt_d = nickel_cnt_q - CNT_W'(1);
                    coin_dime_d  = 1'b0;
                    tmr_start    = 1'b1;
                    state_d      = COIN_PULSE;
                end else begin
                    short_change_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Moore outputs registered from the next state
        busy_d         = (state_d != IDLE);
        eject_soda_d   = (state_d == SODA_PULSE);
        eject_dime_d   = (state_d == COIN_PULSE) && coin_dime_d;
        eject_nickel_d = (state_d == COIN_PULSE) && !coin_dime_d;
        fault_d        = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            coin_dime_q    <= 1'b0;
            soda_cnt_q     <= CNT_W'(SODA_INIT);
            dime_cnt_q     <= CNT_W'(DIME_INIT);
            nickel_cnt_q   <= CNT_W'(NICKEL_INIT);
            short_change_q <= 1'b0;
            busy_q         <= 1'b0;
            eject_soda_q   <= 1'b0;
            eject_dime_q   <= 1'b0;
            eject_nickel_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            coin_dime_q    <= coin_dime_d;
            soda_cnt_q     <= soda_cnt_d;
            dime_cnt_q     <= dime_cnt_d;
            nickel_cnt_q   <= nickel_cnt_d;
            short_change_q <= short_change_d;
            busy_q         <= busy_d;
            eject_soda_q   <= eject_soda_d;
            eject_dime_q   <= eject_dime_d;
            eject_nickel_q <= eject_nickel_d;
            fault_q        <= fault_d;
        end
    end

    assign busy         = busy_q;
    assign eject_soda   = eject_soda_q;
    assign eject_dime   = eject_dime_q;
    assign eject_nickel = eject_nickel_q;
    assign sold_out     = (soda_cnt_q == '0);
    assign short_change = short_change_q;
    assign fault        = fault_q;
    assign soda_cnt     = soda_cnt_q;
    assign dime_cnt     = dime_cnt_q;
    assign nickel_cnt   = nickel_cnt_q;

endmodule
